// File: rtl/vector_control_sequencer.sv
// Registered control decoder that expands vector instructions into
// LANES-wide element-group micro-ops and stalls decode while issuing.
module vector_control_sequencer #(
    parameter int LANES     = 4,
    parameter int MAX_ELEMS = 16,
    parameter int IDX_W     = $clog2(MAX_ELEMS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Opcode,
    input  logic             V,
    input  logic [2:0]       Funct,
    input  logic [IDX_W:0]   vl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Branch,
    output logic             RegW,
    output logic             MemW,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             ALUOp,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             VecOp,
    output logic [IDX_W-1:0] ElemIdx,
    output logic [LANES-1:0] LaneMask,
    output logic             Last,
    output logic             Illegal
);

    localparam int VW = IDX_W + 2;
    localparam logic [VW-1:0]  L_LANES = VW'(LANES);
    localparam logic [IDX_W:0] L_MAX   = (IDX_W + 1)'(MAX_ELEMS);

    typedef enum logic {S_IDLE, S_VSEQ} state_t;

    state_t r_state, w_next_state;

    logic             r_out_valid;
    logic             r_branch, r_regw, r_memw, r_memtoreg;
    logic             r_alusrc, r_aluop, r_vec, r_illegal, r_last;
    logic [1:0]       r_immsrc, r_regsrc;
    logic [IDX_W-1:0] r_elem;
    logic [LANES-1:0] r_mask;
    logic [IDX_W:0]   r_vl;

    logic             w_branch, w_regw, w_memw, w_memtoreg;
    logic             w_alusrc, w_aluop, w_vec, w_illegal;
    logic [1:0]       w_immsrc, w_regsrc;
    logic [IDX_W:0]   w_vl_c;
    logic [VW-1:0]    w_vl_x, w_nidx;
    logic             w_nlast, w_accept, w_fire, w_unused;

    function automatic logic [LANES-1:0] f_mask(
        input logic [VW-1:0] base,
        input logic [VW-1:0] len
    );
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (base + VW'(i)) < len;
        end
        return m;
    endfunction

    assign w_unused = Funct[2];
    assign w_accept = in_valid && in_ready;
    assign w_fire   = r_out_valid && out_ready;
    assign w_vl_c   = (vl > L_MAX) ? L_MAX : vl;
    assign w_vl_x   = {1'b0, w_vl_c};
    assign w_nidx   = {2'b00, r_elem} + L_LANES;
    assign w_nlast  = (w_nidx + L_LANES) >= {1'b0, r_vl};

    always_comb begin
        w_branch   = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_aluop    = 1'b0;
        w_immsrc   = 2'b00;
        w_regsrc   = 2'b00;
        w_vec      = 1'b0;
        w_illegal  = 1'b0;
        unique case (Opcode)
            3'b000: begin
                w_regw  = 1'b1;
                w_aluop = 1'b1;
                w_vec   = V;
                if (Funct[1:0] == 2'b11) begin
                    w_alusrc = 1'b1;
                    w_immsrc = 2'b11;
                end
            end
            3'b100, 3'b101, 3'b110: begin
                w_alusrc = 1'b1;
                if (V) begin
                    w_regw  = 1'b1;
                    w_aluop = 1'b1;
                end else begin
                    w_branch = 1'b1;
                    w_regsrc = 2'b01;
                end
            end
            3'b001: begin
                w_memw   = 1'b1;
                w_alusrc = 1'b1;
                w_regsrc = 2'b10;
                w_vec    = V;
            end
            3'b010: begin
                w_memtoreg = 1'b1;
                w_regw     = 1'b1;
                w_alusrc   = 1'b1;
                w_vec      = V;
            end
            3'b111: begin
                w_branch = 1'b1;
                w_alusrc = 1'b1;
                w_regsrc = 2'b01;
                w_immsrc = V ? 2'b01 : 2'b00;
            end
            3'b011: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_vec && (w_vl_x > L_LANES)) begin
                    w_next_state = S_VSEQ;
                end
            end
            S_VSEQ: begin
                if (w_fire && w_nlast) begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (r_state == S_IDLE) begin
            in_ready = !r_out_valid || out_ready;
        end
    end

    // A flushed cycle also drops whatever decode offered in that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
            r_regw      <= 1'b0;
            r_memw      <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alusrc    <= 1'b0;
            r_aluop     <= 1'b0;
            r_immsrc    <= 2'b00;
            r_regsrc    <= 2'b00;
            r_vec       <= 1'b0;
            r_illegal   <= 1'b0;
            r_elem      <= '0;
            r_mask      <= '0;
            r_last      <= 1'b0;
            r_vl        <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_branch    <= w_branch;
            r_memtoreg  <= w_memtoreg;
            r_alusrc    <= w_alusrc;
            r_aluop     <= w_aluop;
            r_immsrc    <= w_immsrc;
            r_regsrc    <= w_regsrc;
            r_vec       <= w_vec;
            r_illegal   <= w_illegal;
            r_elem      <= '0;
            r_vl        <= w_vl_c;
            if (w_vec) begin
                r_regw <= w_regw && (w_vl_c != '0);
                r_memw <= w_memw && (w_vl_c != '0);
                r_mask <= f_mask('0, w_vl_x);
                r_last <= w_vl_x <= L_LANES;
            end else begin
                r_regw <= w_regw;
                r_memw <= w_memw;
                r_mask <= '1;
                r_last <= 1'b1;
            end
        end else if (w_fire) begin
            if (r_state == S_VSEQ) begin
                r_elem <= w_nidx[IDX_W-1:0];
                r_mask <= f_mask(w_nidx, {1'b0, r_vl});
                r_last <= w_nlast;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Branch    = r_branch;
    assign RegW      = r_regw;
    assign MemW      = r_memw;
    assign MemtoReg  = r_memtoreg;
    assign ALUSrc    = r_alusrc;
    assign ALUOp     = r_aluop;
    assign ImmSrc    = r_immsrc;
    assign RegSrc    = r_regsrc;
    assign VecOp     = r_vec;
    assign ElemIdx   = r_elem;
    assign LaneMask  = r_mask;
    assign Last      = r_last;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Directed bench for vector_control_sequencer with a micro-op scoreboard
// that is filled as instructions are driven and drained on handshakes.
module tb_vector_control_sequencer;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, V, flush, out_valid, out_ready;
    logic [2:0] Opcode, Funct;
    logic [4:0] vl;
    logic       Branch, RegW, MemW, MemtoReg, ALUSrc, ALUOp, VecOp;
    logic       Last, Illegal;
    logic [1:0] ImmSrc, RegSrc;
    logic [3:0] ElemIdx, LaneMask;

    int n_assert = 0;
    int n_fail   = 0;

    logic [20:0] sb[$];
    logic [20:0] w_bus;

    localparam logic [11:0] C_ADDI = 12'b0100_1100_0000;
    localparam logic [11:0] C_BNQ  = 12'b1000_1000_0100;
    localparam logic [11:0] C_RIMM = 12'b0100_1111_0000;
    localparam logic [11:0] C_ILL  = 12'b0000_0000_0001;
    localparam logic [11:0] C_B    = 12'b1000_1001_0100;
    localparam logic [11:0] C_VADD = 12'b0100_0100_0010;
    localparam logic [11:0] C_VLDR = 12'b0101_1000_0010;
    localparam logic [11:0] C_VLD0 = 12'b0001_1000_0010;
    localparam logic [11:0] C_VSTR = 12'b0010_1000_1010;

    vector_control_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .V(V), .Funct(Funct), .vl(vl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .Branch(Branch),
        .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .VecOp(VecOp),
        .ElemIdx(ElemIdx), .LaneMask(LaneMask), .Last(Last),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign w_bus = {Branch, RegW, MemW, MemtoReg, ALUSrc, ALUOp, ImmSrc,
                    RegSrc, VecOp, Illegal, ElemIdx, LaneMask, Last};

    function automatic logic [20:0] mk(input logic [11:0] c,
                                       input logic [3:0] idx,
                                       input logic [3:0] m, input logic l);
        return {c, idx, m, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] c, input logic [3:0] idx,
                        input logic [3:0] m, input logic l);
        sb.push_back(mk(c, idx, m, l));
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_uop", 32'(sb.size()), 1);
            else chk("uop", 32'(w_bus), 32'(sb.pop_front()));
        end
    end

    task automatic send(input logic [2:0] op, input logic v,
                        input logic [2:0] f, input logic [4:0] len);
        bit ok = 0;
        Opcode = op; V = v; Funct = f; vl = len; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_idle", 32'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lo, mw;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        Opcode = '0; V = 1'b0; Funct = '0; vl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_bundle", 32'(w_bus), 0);
        reset = 1'b0;
        out_ready = 1'b1;

        push(C_ADDI, 4'd0, 4'b1111, 1'b1);
        send(3'b100, 1'b1, 3'b000, 5'd0);
        chk("addi_latency", 32'(out_valid), 1);
        drain();

        push(C_BNQ, 4'd0, 4'b1111, 1'b1);
        send(3'b100, 1'b0, 3'b000, 5'd0);
        push(C_RIMM, 4'd0, 4'b1111, 1'b1);
        send(3'b000, 1'b0, 3'b011, 5'd0);
        push(C_ILL, 4'd0, 4'b1111, 1'b1);
        send(3'b011, 1'b1, 3'b000, 5'd16);
        push(C_B, 4'd0, 4'b1111, 1'b1);
        send(3'b111, 1'b1, 3'b000, 5'd0);
        drain();

        for (int b = 0; b < 4; b++)
            push(C_VADD, 4'(b * 4), 4'b1111, b == 3);
        send(3'b000, 1'b1, 3'b000, 5'd16);
        lo = 0;
        repeat (5) begin
            @(negedge clk);
            if (!in_ready) lo++;
        end
        chk("vadd_ready_low", 32'(lo), 3);
        @(posedge clk); #1;
        drain();

        push(C_VLDR, 4'd0, 4'b1111, 1'b0);
        push(C_VLDR, 4'd4, 4'b0011, 1'b1);
        send(3'b010, 1'b1, 3'b000, 5'd6);
        push(C_VLD0, 4'd0, 4'b0000, 1'b1);
        send(3'b010, 1'b1, 3'b000, 5'd0);
        drain();

        for (int b = 0; b < 4; b++)
            push(C_VADD, 4'(b * 4), 4'b1111, b == 3);
        send(3'b000, 1'b1, 3'b000, 5'd20);
        push(C_VADD, 4'd0, 4'b1111, 1'b0);
        push(C_VADD, 4'd4, 4'b1111, 1'b1);
        send(3'b000, 1'b1, 3'b001, 5'd8);
        push(C_ADDI, 4'd0, 4'b1111, 1'b1);
        send(3'b101, 1'b1, 3'b000, 5'd0);
        drain();

        for (int b = 0; b < 4; b++)
            push(C_VADD, 4'(b * 4), 4'b1111, b == 3);
        send(3'b000, 1'b1, 3'b000, 5'd16);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_bundle", 32'(w_bus),
                32'(mk(C_VADD, 4'd4, 4'b1111, 1'b0)));
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        push(C_VSTR, 4'd0, 4'b1111, 1'b0);
        send(3'b001, 1'b1, 3'b000, 5'd16);
        @(posedge clk); #1;
        out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        mw = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid && MemW) mw++;
        end
        chk("flush_no_memw", 32'(mw), 0);
        chk("flush_sb_empty", 32'(sb.size()), 0);
        @(posedge clk); #1;

        Opcode = 3'b100; V = 1'b1; Funct = 3'b000; vl = 5'd0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_discard", 32'(out_valid), 0);

        push(C_VADD, 4'd0, 4'b1111, 1'b0);
        push(C_VADD, 4'd4, 4'b1111, 1'b0);
        send(3'b000, 1'b1, 3'b000, 5'd16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_beat2", 32'(ElemIdx), 8);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_bundle", 32'(w_bus), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 0);
        chk("final_idle", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_control_sequencer.md
Name: vector_control_sequencer

Overview:
Registered, handshaked successor to the combinational main decoder in the decode stage. It decodes Opcode/V/Funct into the same control bundle, adds vector execution for R-type, str and ldr, and expands each vector instruction into element-group micro-ops. While a vector instruction is still issuing, it stalls fetch/decode through in_ready. Lane count, element count and vector length are parametrised or runtime-configurable.

Parameters:
LANES, 4, elements processed per micro-op (power of two, >=1)
MAX_ELEMS, 16, maximum vector length (multiple of LANES)
IDX_W, $clog2(MAX_ELEMS), width of element index

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  sequencer accepts this cycle
Opcode  in  3  instruction opcode
V  in  1  vector/immediate selector bit
Funct  in  3  function field
vl  in  IDX_W+1  active vector length, sampled at accept
flush  in  1  kill in-flight sequence (taken branch)
out_valid  out  1  micro-op control bundle valid
out_ready  in  1  execute stage accepts bundle
Branch, RegW, MemW, MemtoReg, ALUSrc, ALUOp  out  1 each  control signals
ImmSrc  out  2  extend selector
RegSrc  out  2  [0]=PC as SrcA (branches), [1]=Rd as read port 2 (str)
VecOp  out  1  micro-op belongs to a vector instruction
ElemIdx  out  IDX_W  first element index of this micro-op
LaneMask  out  LANES  active lanes of this micro-op
Last  out  1  final micro-op of the instruction
Illegal  out  1  opcode 011 decoded

Behaviour:
- Reset: all outputs 0; in_ready=1; state IDLE.
- Decode table. Control signals are 0 unless listed.
  - 000 V=0, Funct[1:0]=11: ALUSrc=1, ImmSrc=11, RegW=1, ALUOp=1.
  - 000 V=0, other Funct: RegW=1, ALUOp=1.
  - 000 V=1: same as the V=0 row for the given Funct, plus VecOp=1.
  - 100/101/110 V=1 (addi/subi/muli): ALUSrc=1, RegW=1, ALUOp=1.
  - 100/101/110 V=0 (bnq/bgt/blt): Branch=1, ALUSrc=1, RegSrc=01.
  - 001 (str): MemW=1, ALUSrc=1, RegSrc=10; V=1 adds VecOp=1.
  - 010 (ldr): MemtoReg=1, RegW=1, ALUSrc=1; V=1 adds VecOp=1.
  - 111 V=1 (b): Branch=1, ALUSrc=1, ImmSrc=01, RegSrc=01.
  - 111 V=0 (beq): Branch=1, ALUSrc=1, RegSrc=01.
  - 011: all control signals 0, Illegal=1; issued as a single micro-op.
- Output register: the bundle and out_valid are registered. Latency is 1 cycle from accept (in_valid & in_ready) to out_valid.
- Output hold: while out_valid & !out_ready, every output holds stable.
- States:
  - IDLE: in_ready = !out_valid | out_ready.
    - On accept of a scalar op: emit one micro-op with ElemIdx=0, LaneMask=all ones, Last=1; stay in IDLE.
    - On accept of a vector op: latch the bundle and vl, compute beats=ceil(vl/LANES), emit beat 0, go to VSEQ if beats>1.
  - VSEQ: in_ready=0.
    - Each out_ready handshake advances ElemIdx by LANES.
    - The final beat sets Last=1 and returns to IDLE. The next instruction can be accepted in the same cycle the final beat handshakes.
- LaneMask: bit i = (ElemIdx+i < vl). All ones on non-final beats; partial on the final beat when vl mod LANES != 0.
- vl=0 on a vector op: one micro-op with LaneMask=0, RegW=0, MemW=0, Last=1.
- vl>MAX_ELEMS: clamp to MAX_ELEMS.
- flush: at the next edge, out_valid=0 and the state returns to IDLE. An instruction accepted in that same cycle is discarded.
- Priority: reset > flush > handshake.
- ElemIdx never wraps; the maximum issued value is MAX_ELEMS-LANES.

Test Plan:
- Reset mid-VSEQ (beat 2 of 4) -> next cycle out_valid=0, in_ready=1, all outputs 0.
- Scalar ops: addi (Opcode=100, V=1) -> ALUSrc=1, RegW=1, ALUOp=1, Last=1, out_valid one cycle after accept. bnq (Opcode=100, V=0) -> Branch=1, RegSrc=01.
- Vector add (Opcode=000, V=1, vl=16, LANES=4, out_ready=1) -> 4 micro-ops, ElemIdx 0/4/8/12, LaneMask=1111, Last only on 12, in_ready=0 for 3 cycles.
- Vector ldr with vl=6 -> 2 beats, LaneMask 1111 then 0011. vl=0 -> single beat, LaneMask=0000, RegW=0.
- Backpressure: out_ready low for 3 cycles on beat 1 -> ElemIdx=4 and the bundle stay stable, no beat skipped.
- flush during beat 1 of a 4-beat vector str -> out_valid=0 next cycle, in_ready=1, no further MemW pulses. Opcode 011 -> Illegal=1, all control signals 0.
